multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

- Parametrised multi-cycle successor to the single-cycle 16-bit RISC datapath.
- Executes the same 16-bit instruction encoding over a sequencing FSM, with data width and address width generalised.
- Fetches and loads through ready/valid memory ports, so memories may insert wait states.
- Sits between the existing opcode-driven control unit and the external instruction/data memories.

## Interface
- DATA_W, 16, register/ALU/data-memory width; 16..64.
- ADDR_W, 16, PC and memory address width; ≥16.
- RESET_PC, 0, PC value loaded on reset; even.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write  in  1 each  control-unit decodes of `opcode`.
- alu_op  in  2  ALU class from control unit.
- opcode  out  4  IR[15:12]; 0 in reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_ready  in  1  fetch complete.
- imem_rdata  in  16  instruction, valid with imem_ready.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  ALUOut[ADDR_W-1:0].
- dmem_wdata  out  DATA_W  B latch.
- dmem_ready  in  1  access complete.
- dmem_rdata  in  DATA_W  load data, valid with dmem_ready.
- retire  out  1  one-cycle pulse in each instruction's final state.
- cycle_cnt, instr_cnt  out  32 each  performance counters (see Configuration).

## Operation
- Encoding: rs = IR[11:9], rt = IR[8:6], rd = IR[5:3], imm6 = IR[5:0].
- ext = sign-extend(imm6) to DATA_W.
- Register file: 8 × DATA_W, R0 reads 0 and ignores writes.
- Sequencing FSM:
  - IF: imem_req = 1. On imem_ready: IR ← imem_rdata, PC ← PC+2, go to ID.
  - ID: A ← R[rs], B ← R[rt]. Control inputs are now valid. Go to EX.
  - EX: ALUOut ← A op (alu_src ? ext : B); zero ← (result == 0).
    - jump: PC ← {PC[ADDR_W-1:13], IR[11:0], 0}.
    - beq & zero, or bne & !zero: PC ← PC + (ext << 1), where PC is already PC+2.
    - Next state: MEM if mem_read|mem_write; WB if reg_write; else IF.
  - MEM: dmem_req = 1, dmem_we = mem_write. On dmem_ready: loads latch MDR ← dmem_rdata and go to WB; stores go to IF.
  - WB: R[reg_dst ? rd : rt] ← mem_to_reg ? MDR : ALUOut. Go to IF.
- ALU control:
  - alu_op 10 → add.
  - alu_op 01 → sub.
  - alu_op 00 → opcode[2:0]: 000 add, 001 sub, 010 ~A, 011 A<<B, 100 A>>B (logical), 101 and, 110 or, 111 signed slt (result 1/0).
  - Shifts use B[5:0]. Shift amounts ≥ DATA_W yield 0.
- Arithmetic is modulo 2^DATA_W. PC arithmetic is modulo 2^ADDR_W and wraps from max to 0.
- Writes of an undefined combination (reg_write with no WB path) are ignored.

## Timing
- Reset (async, immediate):
  - State IF, PC = RESET_PC.
  - IR, A, B, ALUOut, MDR, all registers = 0.
  - All outputs 0 except imem_addr = RESET_PC.
  - imem_req rises on the first clock edge after rst_n deasserts.
- Reset asserted mid-access drops imem_req/dmem_req in the same cycle. Any in-flight memory response is ignored.
- Handshake:
  - req and addr/wdata/we stay stable until the cycle ready is sampled high.
  - ready with req low is ignored.
  - Zero-wait memory is supported (ready in the same cycle as req).
- Cycles per instruction with zero-wait memory:
  - ALU: 4.
  - load: 5.
  - store: 4.
  - branch/jump: 3.
  - Each memory wait cycle adds 1.
- retire pulses in WB, in MEM for stores, or in EX for instructions ending there.
- Register-file writes are visible to the next instruction's ID. No hazards exist.

## Configuration
- MCDP_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on retire.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Reset and first fetch: hold rst_n low 3 cycles with RESET_PC = 0x0100 → imem_addr = 0x0100 and imem_req = 0 during reset; imem_req = 1 on the first edge after release.
- ALU op: R1 = 5, R2 = 3, add rd = R3 with zero-wait memory → R3 = 8 after 4 cycles; retire in WB; PC advances by 2.
- Load with 2 wait states, ADDR_W = 16: dmem_ready delayed 2 cycles, rdata 0xBEEF → dmem_addr held stable; R[rt] = 0xBEEF; instruction takes 7 cycles.
- Branches:
  - beq with R1 == R2 and imm6 = 0x3E (−2) at PC 0x0010 → PC = 0x000E.
  - bne with equal operands → PC = 0x0012.
  - Both take 3 cycles.
- Wide data, DATA_W = 32: sub 0 − 1 → 0xFFFFFFFF; slt −1 < 1 → 1; write to R0 → R0 reads 0.
- Reset mid-MEM: assert rst_n low while dmem_req = 1 → dmem_req drops the same cycle; PC = RESET_PC. With MCDP_PERF_CNT_EN, cycle_cnt and instr_cnt read 0.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-encoding RISC datapath: IF/ID/EX/MEM/WB sequencer with ready/valid memory ports.
// Optional performance counters are built when MCDP_PERF_CNT_EN is defined.
module multicycle_datapath #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump,
    input  logic              beq,
    input  logic              bne,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [1:0]        alu_op,
    output logic [3:0]        opcode,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              retire,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] SHAMT_LIM = 7'(DATA_W);

    state_t            state, state_nxt;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_q, b_q, alu_out, mdr;
    logic [DATA_W-1:0] rf [8];

    logic [2:0]        rs, rt, rd, dest;
    logic [DATA_W-1:0] ext, opb, alu_res, wb_data;
    logic [ADDR_W-1:0] ext_pc, br_off, jump_tgt;
    logic [5:0]        shamt;
    logic              shift_oob, alu_zero, br_take;
    logic [2:0]        alu_fn;

    assign rs       = ir[11:9];
    assign rt       = ir[8:6];
    assign rd       = ir[5:3];
    assign dest     = reg_dst ? rd : rt;
    assign ext      = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign ext_pc   = {{(ADDR_W-6){ir[5]}}, ir[5:0]};
    assign br_off   = {ext_pc[ADDR_W-2:0], 1'b0};
    assign jump_tgt = {pc[ADDR_W-1:13], ir[11:0], 1'b0};
    assign wb_data  = mem_to_reg ? mdr : alu_out;

    assign opcode     = ir[15:12];
    assign imem_addr  = pc;
    assign dmem_addr  = ADDR_W'(alu_out);
    assign dmem_wdata = b_q;
    assign state_dbg  = state;

    // ALU class 10 forces add, 01 forces sub (branch compare), 00 uses the opcode's low bits.
    always_comb begin
        alu_fn    = 3'b000;
        opb       = alu_src ? ext : b_q;
        shamt     = opb[5:0];
        shift_oob = ({1'b0, shamt} >= SHAMT_LIM);
        alu_res   = '0;
        case (alu_op)
            2'b01:   alu_fn = 3'b001;
            2'b00:   alu_fn = ir[14:12];
            default: alu_fn = 3'b000;
        endcase
        case (alu_fn)
            3'b000: alu_res = a_q + opb;
            3'b001: alu_res = a_q - opb;
            3'b010: alu_res = ~a_q;
            3'b011: alu_res = shift_oob ? '0 : (a_q << shamt);
            3'b100: alu_res = shift_oob ? '0 : (a_q >> shamt);
            3'b101: alu_res = a_q & opb;
            3'b110: alu_res = a_q | opb;
            default: alu_res[0] = ($signed(a_q) < $signed(opb));
        endcase
        alu_zero = (alu_res == '0);
        br_take  = (beq && alu_zero) || (bne && !alu_zero);
    end

    // Memory ports: a request (req with its addr/wdata/we) is held unchanged until
    // the cycle in which ready is sampled high; ready seen while req is low is ignored.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IF: begin
                imem_req = run;
                if (run && imem_ready) state_nxt = S_ID;
            end
            S_ID: state_nxt = S_EX;
            S_EX: begin
                if (mem_read || mem_write) begin
                    state_nxt = S_MEM;
                end else if (reg_write) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_IF;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                if (dmem_ready) begin
                    if (mem_write) begin
                        state_nxt = S_IF;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                retire    = 1'b1;
                state_nxt = S_IF;
            end
            default: state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IF;
        else        state <= state_nxt;
    end

    // run holds off the first fetch request until one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            pc      <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                S_IF: begin
                    if (run && imem_ready) begin
                        ir <= imem_rdata;
                        pc <= pc + ADDR_W'(2);
                    end
                end
                S_ID: begin
                    a_q <= rf[rs];
                    b_q <= rf[rt];
                end
                S_EX: begin
                    alu_out <= alu_res;
                    if (jump)         pc <= jump_tgt;
                    else if (br_take) pc <= pc + br_off;
                end
                S_MEM: begin
                    if (dmem_ready && !mem_write) mdr <= dmem_rdata;
                end
                S_WB: begin
                    if (reg_write && dest != 3'd0) rf[dest] <= wb_data;
                end
                default: ;
            endcase
        end
    end

`ifdef MCDP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath (DATA_W=32, ADDR_W=16, RESET_PC=0x0100) with a small
// control-unit model and wait-state programmable instruction/data memories.
module tb_multicycle_datapath;
    localparam int          DW  = 32;
    localparam int          AW  = 16;
    localparam logic [15:0] RPC = 16'h0100;
    localparam logic [15:0] NOP = 16'hF000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0]    alu_op;
    logic [3:0]    opcode;
    logic          imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire;
    logic [AW-1:0] imem_addr, dmem_addr;
    logic [15:0]   imem_rdata;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic [31:0]   cycle_cnt, instr_cnt;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    multicycle_datapath #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .jump(jump), .beq(beq), .bne(bne),
        .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_op(alu_op), .opcode(opcode),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .retire(retire),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .state_dbg(state_dbg)
    );

    // Control unit: 0-7 R-type ALU, 8 ld, 9 st, A addi, B beq, C bne, D jump, others nop.
    always_comb begin
        {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write} = '0;
        alu_op = 2'b00;
        case (opcode)
            4'h8: begin mem_read = 1; alu_src = 1; alu_op = 2'b10; reg_write = 1; mem_to_reg = 1; end
            4'h9: begin mem_write = 1; alu_src = 1; alu_op = 2'b10; end
            4'hA: begin alu_src = 1; alu_op = 2'b10; reg_write = 1; end
            4'hB: begin beq = 1; alu_op = 2'b01; end
            4'hC: begin bne = 1; alu_op = 2'b01; end
            4'hD: jump = 1;
            4'hE, 4'hF: ;
            default: begin reg_dst = 1; reg_write = 1; end
        endcase
    end

    logic [15:0] imem [256];
    logic [31:0] dmem [16];
    int imem_wait = 0, dmem_wait = 0, icnt, dcnt;

    assign imem_ready = imem_req && (icnt >= imem_wait);
    assign imem_rdata = imem[imem_addr[8:1]];
    assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
    assign dmem_rdata = dmem[dmem_addr[4:1]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: records retire cycles, fetch addresses, completed stores; checks held data requests.
    int          cyc = 0, st_cnt = 0;
    int          retire_q[$];
    logic [15:0] fetch_q[$];
    logic [15:0] st_addr, hold_addr;
    logic [31:0] st_data, hold_data;
    logic        hold_v = 1'b0, hold_we;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (retire) retire_q.push_back(cyc);
            if (imem_req && imem_ready) fetch_q.push_back(imem_addr);
            if (hold_v && dmem_req) begin
                chk("dmem_addr_hold", dmem_addr, hold_addr);
                chk("dmem_wdata_hold", dmem_wdata, hold_data);
                chk("dmem_we_hold", dmem_we, hold_we);
            end
            hold_v    = dmem_req && !dmem_ready;
            hold_addr = dmem_addr;
            hold_data = dmem_wdata;
            hold_we   = dmem_we;
            if (dmem_req && dmem_ready && dmem_we) begin
                st_cnt++;
                st_addr = dmem_addr;
                st_data = dmem_wdata;
            end
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic start();
        @(negedge clk);
        rst_n = 1'b0;
        retire_q.delete();
        fetch_q.delete();
        st_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_store(input string name);
        int s = st_cnt;
        int k = 0;
        while (st_cnt == s && k < 200) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (st_cnt == s) begin
            errors++;
            $display("FAIL %s_timeout: got no store expected a store within 200 cycles", name);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'd0, 32'd5,          32'd3,          32'd8};
        vecs[1]  = '{4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[2]  = '{4'd2, 32'h0F0F_0F0F,  32'd0,          32'hF0F0_F0F0};
        vecs[3]  = '{4'd3, 32'd1,          32'd4,          32'h10};
        vecs[4]  = '{4'd3, 32'd1,          32'd32,         32'd0};
        vecs[5]  = '{4'd3, 32'd1,          32'h41,         32'd2};
        vecs[6]  = '{4'd4, 32'h8000_0000,  32'd31,         32'd1};
        vecs[7]  = '{4'd4, 32'h8000_0000,  32'd32,         32'd0};
        vecs[8]  = '{4'd5, 32'hF0F0_FFFF,  32'h0FF0_0F0F,  32'h00F0_0F0F};
        vecs[9]  = '{4'd6, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
        vecs[10] = '{4'd7, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[11] = '{4'd7, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[12] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        for (int i = 0; i < 16; i++) dmem[i] = '0;

        // Reset and first fetch; program: addi R1,5; addi R2,3; add R3=R1+R2; st R3,4
        clear_imem();
        imem[128] = 16'hA045;
        imem[129] = 16'hA083;
        imem[130] = 16'h0298;
        imem[131] = 16'h90C4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_imem_addr", imem_addr, RPC);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_retire", retire, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_imem_req_low", imem_req, 0);
        @(posedge clk);
        #1 chk("first_edge_imem_req", imem_req, 1);
        chk("first_edge_imem_addr", imem_addr, RPC);
        wait_store("alu_seq");
        chk("alu_add_result", st_data, 32'd8);
        chk("alu_store_addr", st_addr, 16'h0004);
        chk("alu_add_cycles", retire_q[2] - retire_q[1], 4);
        chk("store_cycles", retire_q[3] - retire_q[2], 4);
        chk("alu_pc_advance", fetch_q[3], 16'h0106);

        // ALU table: ld R1,0; ld R2,2; op R3=R1,R2; st R3,4
        for (int i = 0; i < 13; i++) begin
            clear_imem();
            imem[128] = 16'h8040;
            imem[129] = 16'h8082;
            imem[130] = {vecs[i].op, 12'h298};
            imem[131] = 16'h90C4;
            dmem[0] = vecs[i].a;
            dmem[1] = vecs[i].b;
            start();
            wait_store($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_op%0d", i, vecs[i].op), st_data, vecs[i].exp);
        end

        // Load with two data wait states: addi R1,1; ld R4,6; st R4,4
        clear_imem();
        imem[128] = 16'hA041;
        imem[129] = 16'h8106;
        imem[130] = 16'h9104;
        dmem[3] = 32'h0000_BEEF;
        dmem_wait = 2;
        start();
        wait_store("load_wait");
        chk("load_wait_data", st_data, 32'h0000_BEEF);
        chk("load_wait_cycles", retire_q[1] - retire_q[0], 7);
        chk("load_wait_st_addr", st_addr, 16'h0004);
        dmem_wait = 0;

        // Jump to 0x10; beq taken back to 0x0E; bne not taken to 0x10
        clear_imem();
        imem[128] = 16'hD008;
        imem[8]   = 16'hB2BE;
        imem[7]   = 16'hC285;
        start();
        repeat (25) @(posedge clk);
        chk("jump_target", fetch_q[1], 16'h0010);
        chk("beq_taken_pc", fetch_q[2], 16'h000E);
        chk("bne_not_taken_pc", fetch_q[3], 16'h0010);
        chk("beq_taken_again", fetch_q[4], 16'h000E);
        chk("jump_cycles", retire_q[1] - retire_q[0], 3);
        chk("beq_cycles", retire_q[2] - retire_q[1], 3);

        // R0 ignores writes: addi R0,5; st R0,4
        clear_imem();
        imem[128] = 16'hA005;
        imem[129] = 16'h9004;
        start();
        wait_store("r0");
        chk("r0_reads_zero", st_data, 32'd0);

        // Reset while a load is stalled in MEM
        clear_imem();
        imem[128] = 16'h8040;
        dmem_wait = 20;
        start();
        begin
            int k = 0;
            while (!dmem_req && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        chk("mid_mem_req_seen", dmem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_mem_dmem_req_drop", dmem_req, 0);
        chk("mid_mem_imem_req", imem_req, 0);
        chk("mid_mem_pc", imem_addr, RPC);
        chk("mid_mem_cycle_cnt", cycle_cnt, 0);
        chk("mid_mem_instr_cnt", instr_cnt, 0);
        chk("mid_mem_state", state_dbg, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_wait = 0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
